// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the multiplier and the fast/slow dividers.
package arith_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mul_state_t;

    localparam int MUL_N_DEFAULT = 4;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Request/result bundle of the sequential multiplier; the requester owns the master side.
interface shift_add_multiplier_if
    import arith_pkg::*;
#(
    parameter int N = MUL_N_DEFAULT
);

    logic             start;
    logic [N-1:0]     multiplicand;
    logic [N-1:0]     multiplier;
    logic [2*N-1:0]   product;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output multiplicand,
        output multiplier,
        input  product,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  multiplicand,
        input  multiplier,
        output product,
        output busy,
        output done
    );

endinterface

// File: rtl/mul_step.sv
// One shift-and-add iteration: conditional add of the multiplicand, then shift {acc,mq} right by one.
module mul_step #(
    parameter int N = 4
) (
    input  logic [N:0]     i_acc,
    input  logic [N-1:0]   i_mq,
    input  logic [N-1:0]   i_mcand,
    output logic [N:0]     o_acc_next,
    output logic [N-1:0]   o_mq_next,
    output logic [2*N-1:0] o_product
);

    logic [N:0] w_addend;
    logic [N:0] w_sum;

    // The extra sum bit carries out of the N-bit add and is shifted back into acc.
    assign w_addend   = i_mq[0] ? {1'b0, i_mcand} : '0;
    assign w_sum      = i_acc + w_addend;

    assign o_acc_next = {1'b0, w_sum[N:1]};
    assign o_mq_next  = {w_sum[0], i_mq[N-1:1]};
    assign o_product  = {w_sum, i_mq[N-1:1]};

endmodule

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned N x N multiplier: one partial product per cycle, 2N-bit result after N cycles.
module shift_add_multiplier
    import arith_pkg::*;
#(
    parameter int N = MUL_N_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    shift_add_multiplier_if.slave   bus
);

    localparam int CW = $clog2(N) + 1;

    mul_state_t       r_state;
    logic [N-1:0]     r_mcand;
    logic [N-1:0]     r_mq;
    logic [N:0]       r_acc;
    logic [CW-1:0]    r_cnt;
    logic [2*N-1:0]   r_product;
    logic             r_busy;
    logic             r_done;

    logic [N:0]       w_acc_next;
    logic [N-1:0]     w_mq_next;
    logic [2*N-1:0]   w_product;
    logic             w_last;

    mul_step #(
        .N (N)
    ) u_step (
        .i_acc      (r_acc),
        .i_mq       (r_mq),
        .i_mcand    (r_mcand),
        .o_acc_next (w_acc_next),
        .o_mq_next  (w_mq_next),
        .o_product  (w_product)
    );

    assign w_last = (r_cnt == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_mcand   <= '0;
            r_mq      <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_mcand <= bus.multiplicand;
                        r_mq    <= bus.multiplier;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_acc <= w_acc_next;
                    r_mq  <= w_mq_next;
                    r_cnt <= r_cnt + CW'(1);
                    // start is deliberately not looked at here: no queuing while iterating.
                    if (w_last) begin
                        r_product <= w_product;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.product = r_product;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for the 4-bit shift-and-add multiplier with hand-computed products.
module tb_shift_add_multiplier;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    shift_add_multiplier_if #(.N(4)) bus ();

    shift_add_multiplier #(
        .N (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // Issue one operation, scramble the operands after acceptance, and check the full timeline.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp, input string tag);
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.start        = 1'b1;
        step();
        bus.start        = 1'b0;
        bus.multiplicand = 4'($urandom);
        bus.multiplier   = 4'($urandom);
        chk({tag, " busy_e0"}, 32'(bus.busy), 1);
        chk({tag, " done_e0"}, 32'(bus.done), 0);
        repeat (3) step();
        chk({tag, " busy_e3"}, 32'(bus.busy), 1);
        chk({tag, " done_e3"}, 32'(bus.done), 0);
        step();
        chk({tag, " done_e4"}, 32'(bus.done), 1);
        chk({tag, " busy_e4"}, 32'(bus.busy), 0);
        chk({tag, " product"}, 32'(bus.product), 32'(exp));
        step();
        chk({tag, " done_clear"}, 32'(bus.done), 0);
        chk({tag, " product_hold"}, 32'(bus.product), 32'(exp));
        $display("op %s: %0d x %0d -> %0d (expected %0d)", tag, a, b, bus.product, exp);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        step();
        step();
        rst = 1'b0;
        chk("reset product", 32'(bus.product), 0);
        chk("reset busy", 32'(bus.busy), 0);
        chk("reset done", 32'(bus.done), 0);
        $display("reset: product=%0d busy=%0d done=%0d", bus.product, bus.busy, bus.done);

        run_op(4'd3, 4'd2, 8'd6, "3x2");
        run_op(4'd15, 4'd15, 8'hE1, "15x15");
        run_op(4'd0, 4'd9, 8'd0, "0x9");

        // start held high: 7x2 accepted, start at E4 ignored, 13x4 accepted at E5
        bus.multiplicand = 4'd7;
        bus.multiplier   = 4'd2;
        bus.start        = 1'b1;
        step();
        bus.multiplicand = 4'd13;
        bus.multiplier   = 4'd4;
        repeat (4) step();
        chk("held first done", 32'(bus.done), 1);
        chk("held first product", 32'(bus.product), 14);
        chk("held first busy", 32'(bus.busy), 0);
        step();
        chk("held restart busy", 32'(bus.busy), 1);
        chk("held restart done", 32'(bus.done), 0);
        bus.multiplicand = 4'd1;
        bus.multiplier   = 4'd1;
        repeat (3) step();
        chk("held e8 done", 32'(bus.done), 0);
        bus.start = 1'b0;
        step();
        chk("held second done", 32'(bus.done), 1);
        chk("held second product", 32'(bus.product), 52);
        step();
        chk("held idle busy", 32'(bus.busy), 0);
        chk("held idle done", 32'(bus.done), 0);
        $display("held start: second product=%0d (expected 52)", bus.product);

        // start during RUN is ignored
        bus.multiplicand = 4'd5;
        bus.multiplier   = 4'd3;
        bus.start        = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        bus.multiplicand = 4'd1;
        bus.multiplier   = 4'd1;
        bus.start        = 1'b1;
        step();
        bus.start = 1'b0;
        chk("midrun busy", 32'(bus.busy), 1);
        step();
        step();
        chk("midrun done", 32'(bus.done), 1);
        chk("midrun product", 32'(bus.product), 15);
        step();
        chk("midrun no restart", 32'(bus.busy), 0);
        $display("midrun start: product=%0d (expected 15)", bus.product);

        // reset mid-RUN discards the operation
        bus.multiplicand = 4'd5;
        bus.multiplier   = 4'd5;
        bus.start        = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort busy", 32'(bus.busy), 0);
        chk("abort product", 32'(bus.product), 0);
        chk("abort done", 32'(bus.done), 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("abort no done", 32'(bus.done), 0);
        end
        $display("reset mid-run: busy=%0d product=%0d", bus.busy, bus.product);

        // rst wins over start in the same cycle
        rst       = 1'b1;
        bus.start = 1'b1;
        step();
        rst       = 1'b0;
        bus.start = 1'b0;
        chk("rst priority busy", 32'(bus.busy), 0);
        $display("rst+start: busy=%0d", bus.busy);

        run_op(4'd5, 4'd5, 8'd25, "5x5");

        // divider round trip: Q2.2 quotient 3.5 = 14, times divisor 2, >> 2 gives dividend 7
        run_op(4'd14, 4'd2, 8'd28, "14x2");
        chk("roundtrip dividend", 32'(bus.product >> 2), 7);
        $display("roundtrip: dividend=%0d (expected 7)", bus.product >> 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
